// File: rtl/mips_cpu_mem_pkg.sv
// Shared definitions for the CPU-side memory responders: access FSM states
// and the default placement of the data window in the address map.
package mips_cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_t;

  localparam logic [31:0] DATA_BASE_ADDR  = 32'h0000_1000;
  localparam int          MAX_WAIT_CYCLES = 15;

endpackage

// File: rtl/mips_cpu_mem_array.sv
// Word storage with one asynchronous read port and two synchronous write
// ports. Port 0 (backdoor load) wins over port 1 (CPU) on the same index.
module mips_cpu_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we0_i,
  input  logic [IDX_W-1:0] idx0_i,
  input  logic [31:0]      wdata0_i,
  input  logic             we1_i,
  input  logic [IDX_W-1:0] idx1_i,
  input  logic [31:0]      wdata1_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic        port1_blocked;

  assign port1_blocked = we0_i && (idx0_i == idx1_i);

  // Commit both write ports; the CPU port yields when the load hits the same word.
  // NOTE: the array has no reset branch on purpose -- contents survive reset so
  // a preloaded image stays valid, and it lets the tools map this onto RAM.
  always_ff @(posedge clk) begin
    if (we0_i) begin
      mem_q[idx0_i] <= wdata0_i;
    end
    if (we1_i && !port1_blocked) begin
      mem_q[idx1_i] <= wdata1_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_cpu_data_ram.sv
// Data-memory responder for the CPU's data port: combinational read,
// single-cycle write, optional wait states signalled through clk_enable,
// sticky out-of-window error flag and a backdoor preload port.
module mips_cpu_data_ram
  import mips_cpu_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DATA_BASE_ADDR,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    data_address,
  input  logic                           data_read,
  input  logic                           data_write,
  input  logic [31:0]                    data_writedata,
  output logic [31:0]                    data_readdata,
  output logic                           clk_enable,
  output logic                           addr_error,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_index,
  input  logic [31:0]                    load_data
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WINDOW_END = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT   = (WAIT_CYCLES >= 2) ? 4'(WAIT_CYCLES - 2) : 4'd0;

  if (WINDOW_END > 33'h1_0000_0000) begin : g_bad_window
    $error("mips_cpu_data_ram: BASE_ADDR + 4*DEPTH_WORDS exceeds 2^32");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("mips_cpu_data_ram: DEPTH_WORDS must be a power of two >= 2");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT_CYCLES) begin : g_bad_wait
    $error("mips_cpu_data_ram: WAIT_CYCLES must be in 0..15");
  end

  // Address decode: window check done in 33 bits so a window ending at 2^32 works.
  logic             req;
  logic             in_range;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;

  assign req      = data_read | data_write;
  assign in_range = ({1'b0, data_address} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, data_address} <  WINDOW_END);
  assign offset   = data_address - BASE_ADDR;
  assign idx      = IDX_W'(offset >> 2);

  // Access sequencing state.
  mem_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       complete;
  logic       cpu_enable;
  logic       addr_error_q;

  // Next-state decode; also flags the completion cycle and the stall output.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    complete   = 1'b0;
    cpu_enable = 1'b1;
    if (WAIT_CYCLES == 0) begin
      complete = req;
    end else begin
      case (state_q)
        IDLE: begin
          cpu_enable = ~req;
          if (req) begin
            if (WAIT_CYCLES == 1) begin
              state_d = DONE;
            end else begin
              state_d = BUSY;
              cnt_d   = CNT_INIT;
            end
          end
        end
        BUSY: begin
          cpu_enable = 1'b0;
          if (cnt_q == 4'd0) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        DONE: begin
          complete = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Register FSM, wait counter and the sticky out-of-window flag.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and simulation matches the synthesised netlist.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (complete && !in_range) begin
        addr_error_q <= 1'b1;
      end
    end
  end

  logic        cpu_we;
  logic [31:0] array_rdata;

  // A CPU write only lands on its completion edge, inside the window, outside reset.
  assign cpu_we = complete && data_write && in_range && !reset;

  mips_cpu_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk      (clk),
    .we0_i    (load_en),
    .idx0_i   (load_index),
    .wdata0_i (load_data),
    .we1_i    (cpu_we),
    .idx1_i   (idx),
    .wdata1_i (data_writedata),
    .raddr_i  (idx),
    .rdata_o  (array_rdata)
  );

  assign data_readdata = (data_read && in_range) ? array_rdata : 32'h0;
  assign clk_enable    = reset | cpu_enable;
  assign addr_error    = addr_error_q;

endmodule

// File: tb/tb_mips_cpu_data_ram.sv
// Bench for mips_cpu_data_ram: four instances with 0, 1, 3 and 4 wait states,
// a vector table for the zero-wait instance and scoreboarded multi-cycle
// sequences for the stalling ones.
module tb_mips_cpu_data_ram;

  localparam int          NDUT = 4;
  localparam int          D_W0 = 0;
  localparam int          D_W1 = 1;
  localparam int          D_W3 = 2;
  localparam int          D_W4 = 3;
  localparam logic [31:0] BASE = 32'h0000_1000;

  function automatic int wait_of(input int g);
    case (g)
      0:       return 0;
      1:       return 1;
      2:       return 3;
      default: return 4;
    endcase
  endfunction

  typedef struct packed {
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_data;
  } drv_t;

  typedef struct {
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_data;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ce;
    logic        exp_aerr;
  } vec_t;

  typedef struct {
    logic        is_rd;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  drv_t        drv     [NDUT];
  logic [31:0] rdata_o [NDUT];
  logic        ce_o    [NDUT];
  logic        aerr_o  [NDUT];

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  vec_t vec [14];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mips_cpu_data_ram #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (1024),
      .WAIT_CYCLES (wait_of(g))
    ) u_dut (
      .clk            (clk),
      .reset          (drv[g].reset),
      .data_address   (drv[g].addr),
      .data_read      (drv[g].rd),
      .data_write     (drv[g].wr),
      .data_writedata (drv[g].wdata),
      .data_readdata  (rdata_o[g]),
      .clk_enable     (ce_o[g]),
      .addr_error     (aerr_o[g]),
      .load_en        (drv[g].ld_en),
      .load_index     (drv[g].ld_idx),
      .load_data      (drv[g].ld_data)
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    drv[k].rd = 1'b0;
    drv[k].wr = 1'b0;
  endtask

  // Drive one request, count stall cycles until clk_enable rises, compare the
  // scoreboarded read value in the completion cycle. Returns at posedge+1
  // with the request still driven so the caller can chain another access.
  task automatic access(input int k, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input int exp_stalls,
                        input string name);
    int   stalls = 0;
    logic done   = 1'b0;
    exp_t e;
    drv[k].rd    = rd;
    drv[k].wr    = wr;
    drv[k].addr  = addr;
    drv[k].wdata = wdata;
    sb_q.push_back('{rd, exp_rd, name});
    for (int c = 0; c < 32 && !done; c++) begin
      @(negedge clk);
      if (ce_o[k]) begin
        e = sb_q.pop_front();
        if (e.is_rd) check($sformatf("%s rdata", e.name), rdata_o[k], e.val);
        done = 1'b1;
      end else begin
        stalls++;
      end
    end
    check_bit($sformatf("%s completed", name), done, 1'b1);
    if (!done && sb_q.size() > 0) void'(sb_q.pop_front());
    check($sformatf("%s stalls", name), 32'(stalls), 32'(exp_stalls));
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Zero-wait table: {ld_en, ld_idx, ld_data, rd, wr, addr, wdata, exp_rdata, exp_ce, exp_aerr}
    vec[0]  = '{1'b0, 10'd0, 32'h0,          1'b1, 1'b0, 32'h0000_100C, 32'h0,          32'hDEAD_BEEF, 1'b1, 1'b0};
    vec[1]  = '{1'b0, 10'd0, 32'h0,          1'b0, 1'b1, 32'h0000_1004, 32'h1111_2222, 32'h0,          1'b1, 1'b0};
    vec[2]  = '{1'b0, 10'd0, 32'h0,          1'b1, 1'b0, 32'h0000_1004, 32'h0,          32'h1111_2222, 1'b1, 1'b0};
    vec[3]  = '{1'b0, 10'd0, 32'h0,          1'b1, 1'b1, 32'h0000_1004, 32'h3333_4444, 32'h1111_2222, 1'b1, 1'b0};
    vec[4]  = '{1'b0, 10'd0, 32'h0,          1'b1, 1'b0, 32'h0000_1004, 32'h0,          32'h3333_4444, 1'b1, 1'b0};
    vec[5]  = '{1'b1, 10'd5, 32'hAAAA_0000, 1'b0, 1'b1, 32'h0000_1014, 32'h5555_FFFF, 32'h0,          1'b1, 1'b0};
    vec[6]  = '{1'b0, 10'd0, 32'h0,          1'b1, 1'b0, 32'h0000_1014, 32'h0,          32'hAAAA_0000, 1'b1, 1'b0};
    vec[7]  = '{1'b0, 10'd0, 32'h0,          1'b0, 1'b1, 32'h0000_1FFC, 32'hCAFE_F00D, 32'h0,          1'b1, 1'b0};
    vec[8]  = '{1'b0, 10'd0, 32'h0,          1'b1, 1'b0, 32'h0000_1FFC, 32'h0,          32'hCAFE_F00D, 1'b1, 1'b0};
    vec[9]  = '{1'b0, 10'd0, 32'h0,          1'b0, 1'b1, 32'h0000_0FFC, 32'hBAD0_BAD0, 32'h0,          1'b1, 1'b0};
    vec[10] = '{1'b0, 10'd0, 32'h0,          1'b1, 1'b0, 32'h0000_2000, 32'h0,          32'h0,          1'b1, 1'b1};
    vec[11] = '{1'b0, 10'd0, 32'h0,          1'b1, 1'b0, 32'h0000_1FFC, 32'h0,          32'hCAFE_F00D, 1'b1, 1'b1};
    vec[12] = '{1'b0, 10'd0, 32'h0,          1'b0, 1'b0, 32'h0000_1000, 32'h0,          32'h0,          1'b1, 1'b1};
    vec[13] = '{1'b0, 10'd0, 32'h0,          1'b1, 1'b0, 32'h0000_1014, 32'h0,          32'hAAAA_0000, 1'b1, 1'b1};

    for (int i = 0; i < NDUT; i++) begin
      drv[i]       = '0;
      drv[i].reset = 1'b1;
    end

    // Preload through the backdoor while every instance is held in reset.
    next_cycle();
    drv[D_W0].ld_en = 1'b1; drv[D_W0].ld_idx = 10'd3; drv[D_W0].ld_data = 32'hDEAD_BEEF;
    drv[D_W1].ld_en = 1'b1; drv[D_W1].ld_idx = 10'd0; drv[D_W1].ld_data = 32'h0A0A_0A0A;
    drv[D_W4].ld_en = 1'b1; drv[D_W4].ld_idx = 10'd2; drv[D_W4].ld_data = 32'h7777_7777;
    next_cycle();
    drv[D_W0].ld_en = 1'b0;
    drv[D_W4].ld_en = 1'b0;
    drv[D_W1].ld_idx = 10'd1; drv[D_W1].ld_data = 32'h1B1B_1B1B;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check_bit($sformatf("reset ce dut%0d", i), ce_o[i], 1'b1);
      check_bit($sformatf("reset aerr dut%0d", i), aerr_o[i], 1'b0);
    end
    next_cycle();
    for (int i = 0; i < NDUT; i++) begin
      drv[i].ld_en = 1'b0;
      drv[i].reset = 1'b0;
    end
    next_cycle();

    // Zero-wait instance: table-driven vectors, one per cycle.
    for (int i = 0; i < 14; i++) begin
      drv[D_W0].ld_en   = vec[i].ld_en;
      drv[D_W0].ld_idx  = vec[i].ld_idx;
      drv[D_W0].ld_data = vec[i].ld_data;
      drv[D_W0].rd      = vec[i].rd;
      drv[D_W0].wr      = vec[i].wr;
      drv[D_W0].addr    = vec[i].addr;
      drv[D_W0].wdata   = vec[i].wdata;
      @(negedge clk);
      check($sformatf("vec%0d rdata", i), rdata_o[D_W0], vec[i].exp_rdata);
      check_bit($sformatf("vec%0d ce", i), ce_o[D_W0], vec[i].exp_ce);
      check_bit($sformatf("vec%0d aerr", i), aerr_o[D_W0], vec[i].exp_aerr);
      next_cycle();
    end
    drv[D_W0].ld_en = 1'b0;
    idle(D_W0);

    // Reset clears the sticky flag but leaves the RAM contents alone.
    drv[D_W0].reset = 1'b1;
    @(negedge clk);
    check_bit("w0 ce in reset", ce_o[D_W0], 1'b1);
    next_cycle();
    drv[D_W0].reset = 1'b0;
    access(D_W0, 1'b1, 1'b0, 32'h0000_1FFC, 32'h0, 32'hCAFE_F00D, 0, "w0 read after reset");
    idle(D_W0);
    @(negedge clk);
    check_bit("w0 aerr cleared", aerr_o[D_W0], 1'b0);
    next_cycle();
    access(D_W0, 1'b1, 1'b0, 32'h0000_100C, 32'h0, 32'hDEAD_BEEF, 0, "w0 preload read");
    idle(D_W0);

    // Three wait states: write, then read it back, then an out-of-window read.
    access(D_W3, 1'b0, 1'b1, 32'h0000_1010, 32'h1234_5678, 32'h0, 3, "w3 write");
    idle(D_W3);
    @(negedge clk);
    check_bit("w3 idle ce", ce_o[D_W3], 1'b1);
    next_cycle();
    access(D_W3, 1'b1, 1'b0, 32'h0000_1010, 32'h0, 32'h1234_5678, 3, "w3 read");
    access(D_W3, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 32'h0, 3, "w3 oow read");
    idle(D_W3);
    @(negedge clk);
    check_bit("w3 aerr set", aerr_o[D_W3], 1'b1);
    next_cycle();

    // One wait state: back-to-back reads give clk_enable 0,1,0,1.
    access(D_W1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 32'h0A0A_0A0A, 1, "w1 read0");
    access(D_W1, 1'b1, 1'b0, 32'h0000_1004, 32'h0, 32'h1B1B_1B1B, 1, "w1 read1");
    idle(D_W1);
    @(negedge clk);
    check_bit("w1 idle ce", ce_o[D_W1], 1'b1);
    check_bit("w1 aerr", aerr_o[D_W1], 1'b0);
    next_cycle();

    // Four wait states: reset lands in the second BUSY cycle of a write.
    drv[D_W4].wr    = 1'b1;
    drv[D_W4].addr  = 32'h0000_1008;
    drv[D_W4].wdata = 32'h9999_9999;
    @(negedge clk);
    check_bit("w4 stall idle", ce_o[D_W4], 1'b0);
    next_cycle();
    @(negedge clk);
    check_bit("w4 stall busy1", ce_o[D_W4], 1'b0);
    next_cycle();
    drv[D_W4].reset = 1'b1;
    @(negedge clk);
    check_bit("w4 ce in reset", ce_o[D_W4], 1'b1);
    next_cycle();
    drv[D_W4].reset = 1'b0;
    idle(D_W4);
    @(negedge clk);
    check_bit("w4 ce after reset", ce_o[D_W4], 1'b1);
    next_cycle();
    access(D_W4, 1'b1, 1'b0, 32'h0000_1008, 32'h0, 32'h7777_7777, 4, "w4 read after abort");
    idle(D_W4);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
